// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with single-cycle ops and an iterative
//               restoring divider; one registered result per OUT_VALID pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16   // >= 4, power of two
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CARRY,
    output logic             DIV_ZERO,
    output logic             Arith_flag,
    output logic             Logic_flag,
    output logic             CMP_flag,
    output logic             Shift_flag
);

    localparam int c_SH_W  = $clog2(WIDTH);
    localparam int c_CNT_W = c_SH_W + 1;

    localparam logic [3:0] c_OP_DIV = 4'h3;

    // Class vector order: {arith, logic, cmp, shift}
    localparam logic [3:0] c_CLS_ARITH = 4'b1000;
    localparam logic [3:0] c_CLS_LOGIC = 4'b0100;
    localparam logic [3:0] c_CLS_CMP   = 4'b0010;
    localparam logic [3:0] c_CLS_SHIFT = 4'b0001;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t             r_state_q,     w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic [WIDTH-1:0]   r_rem_q,       w_rem_d;
    logic [WIDTH-1:0]   r_quo_q,       w_quo_d;
    logic [WIDTH-1:0]   r_dvs_q,       w_dvs_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0]   r_alu_out_q,   w_alu_out_d;
    logic               r_carry_q,     w_carry_d;
    logic               r_div_zero_q,  w_div_zero_d;
    logic [3:0]         r_cls_q,       w_cls_d;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_prod;
    logic [c_SH_W-1:0]  w_sh;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_carry;
    logic               w_res_dz;
    logic [3:0]         w_res_cls;
    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_trial;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};
    assign w_prod = A * B;
    assign w_sh   = B[c_SH_W-1:0];

    always_comb begin
        w_res       = '0;
        w_res_carry = 1'b0;
        w_res_dz    = 1'b0;
        w_res_cls   = c_CLS_ARITH;
        case (ALU_FUN)
            4'h0: begin w_res = w_sum[WIDTH-1:0];  w_res_carry = w_sum[WIDTH];  end
            4'h1: begin w_res = w_diff[WIDTH-1:0]; w_res_carry = w_diff[WIDTH]; end
            4'h2: w_res = w_prod;
            // Only reaches the output path when B == 0; nonzero B goes to the divider.
            4'h3: begin w_res = '1; w_res_dz = 1'b1; end
            4'h4: begin w_res = A & B;    w_res_cls = c_CLS_LOGIC; end
            4'h5: begin w_res = A | B;    w_res_cls = c_CLS_LOGIC; end
            4'h6: begin w_res = ~(A & B); w_res_cls = c_CLS_LOGIC; end
            4'h7: begin w_res = ~(A | B); w_res_cls = c_CLS_LOGIC; end
            4'h8: begin w_res = A ^ B;    w_res_cls = c_CLS_LOGIC; end
            4'h9: begin w_res = ~(A ^ B); w_res_cls = c_CLS_LOGIC; end
            4'hA: begin
                w_res     = (A == B) ? {{(WIDTH-2){1'b0}}, 2'd1} : '0;
                w_res_cls = c_CLS_CMP;
            end
            4'hB: begin
                w_res     = (A > B) ? {{(WIDTH-2){1'b0}}, 2'd2} : '0;
                w_res_cls = c_CLS_CMP;
            end
            4'hC: begin
                w_res     = (A < B) ? {{(WIDTH-2){1'b0}}, 2'd3} : '0;
                w_res_cls = c_CLS_CMP;
            end
            4'hD: begin w_res = A >> w_sh; w_res_cls = c_CLS_SHIFT; end
            4'hE: begin w_res = A << w_sh; w_res_cls = c_CLS_SHIFT; end
            4'hF: begin w_res = $unsigned($signed(A) >>> w_sh); w_res_cls = c_CLS_SHIFT; end
            default: w_res = '0;
        endcase
    end

    // One restoring step: after a successful trial the remainder is below
    // the divisor, so the low WIDTH bits of the difference are exact.
    assign w_rem_sh  = {r_rem_q, r_quo_q[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs_q});
    assign w_trial   = w_rem_sh[WIDTH-1:0] - r_dvs_q;
    assign w_quo_nxt = {r_quo_q[WIDTH-2:0], w_ge};
    assign w_rem_nxt = w_ge ? w_trial : w_rem_sh[WIDTH-1:0];

    assign w_in_ready = (r_state_q == S_IDLE) && !RST;
    assign w_accept   = IN_VALID && w_in_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rem_d       = r_rem_q;
        w_quo_d       = r_quo_q;
        w_dvs_d       = r_dvs_q;
        w_out_valid_d = 1'b0;
        w_alu_out_d   = r_alu_out_q;
        w_carry_d     = r_carry_q;
        w_div_zero_d  = r_div_zero_q;
        w_cls_d       = r_cls_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if ((ALU_FUN == c_OP_DIV) && (B != '0)) begin
                        w_state_d = S_DIV;
                        w_dvs_d   = B;
                        w_quo_d   = A;
                        w_rem_d   = '0;
                        w_cnt_d   = c_CNT_W'(WIDTH);
                    end else begin
                        w_out_valid_d = 1'b1;
                        w_alu_out_d   = w_res;
                        w_carry_d     = w_res_carry;
                        w_div_zero_d  = w_res_dz;
                        w_cls_d       = w_res_cls;
                    end
                end
            end
            S_DIV: begin
                w_rem_d = w_rem_nxt;
                w_quo_d = w_quo_nxt;
                w_cnt_d = r_cnt_q - c_CNT_W'(1);
                if (r_cnt_q == c_CNT_W'(1)) begin
                    w_state_d     = S_IDLE;
                    w_out_valid_d = 1'b1;
                    w_alu_out_d   = w_quo_nxt;
                    w_carry_d     = 1'b0;
                    w_div_zero_d  = 1'b0;
                    w_cls_d       = c_CLS_ARITH;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_rem_q       <= '0;
            r_quo_q       <= '0;
            r_dvs_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_alu_out_q   <= '0;
            r_carry_q     <= 1'b0;
            r_div_zero_q  <= 1'b0;
            r_cls_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rem_q       <= w_rem_d;
            r_quo_q       <= w_quo_d;
            r_dvs_q       <= w_dvs_d;
            r_out_valid_q <= w_out_valid_d;
            r_alu_out_q   <= w_alu_out_d;
            r_carry_q     <= w_carry_d;
            r_div_zero_q  <= w_div_zero_d;
            r_cls_q       <= w_cls_d;
        end
    end

    assign IN_READY   = w_in_ready;
    assign OUT_VALID  = r_out_valid_q;
    assign ALU_OUT    = r_alu_out_q;
    assign CARRY      = r_carry_q;
    assign DIV_ZERO   = r_div_zero_q;
    assign Arith_flag = r_cls_q[3];
    assign Logic_flag = r_cls_q[2];
    assign CMP_flag   = r_cls_q[1];
    assign Shift_flag = r_cls_q[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ALU_FUN = 4'h0;
    logic         OUT_VALID;
    logic [W-1:0] ALU_OUT;
    logic         CARRY, DIV_ZERO;
    logic         Arith_flag, Logic_flag, CMP_flag, Shift_flag;

    alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID),
        .ALU_OUT(ALU_OUT), .CARRY(CARRY), .DIV_ZERO(DIV_ZERO),
        .Arith_flag(Arith_flag), .Logic_flag(Logic_flag),
        .CMP_flag(CMP_flag), .Shift_flag(Shift_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        dz;
        logic [3:0]  cls;   // {arith, logic, cmp, shift}
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   w     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        exp_t        e;
        logic [16:0] t;
        logic [31:0] p;
        logic [15:0] r;
        int          sh;
        e.res = '0; e.carry = 1'b0; e.dz = 1'b0; e.cls = 4'b1000; e.edge_no = 0;
        sh = int'(b[3:0]);
        case (f)
            4'h0: begin t = {1'b0, a} + {1'b0, b}; e.res = t[15:0]; e.carry = t[16]; end
            4'h1: begin e.res = a - b; e.carry = (a < b); end
            4'h2: begin p = {16'h0, a} * {16'h0, b}; e.res = p[15:0]; end
            4'h3: begin
                if (b == 16'h0) begin e.res = 16'hFFFF; e.dz = 1'b1; end
                else e.res = a / b;
            end
            4'h4: begin e.res = a & b;    e.cls = 4'b0100; end
            4'h5: begin e.res = a | b;    e.cls = 4'b0100; end
            4'h6: begin e.res = ~(a & b); e.cls = 4'b0100; end
            4'h7: begin e.res = ~(a | b); e.cls = 4'b0100; end
            4'h8: begin e.res = a ^ b;    e.cls = 4'b0100; end
            4'h9: begin e.res = ~(a ^ b); e.cls = 4'b0100; end
            4'hA: begin e.res = (a == b) ? 16'd1 : 16'd0; e.cls = 4'b0010; end
            4'hB: begin e.res = (a > b)  ? 16'd2 : 16'd0; e.cls = 4'b0010; end
            4'hC: begin e.res = (a < b)  ? 16'd3 : 16'd0; e.cls = 4'b0010; end
            4'hD: begin e.res = a >> sh; e.cls = 4'b0001; end
            4'hE: begin e.res = a << sh; e.cls = 4'b0001; end
            default: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[15], r[15:1]};
                e.res = r; e.cls = 4'b0001;
            end
        endcase
        return e;
    endfunction

    // Offer an op at the current negedge, wait for IN_READY, record the
    // expectation, and return one negedge after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                        output int waits);
        exp_t e;
        waits = 0;
        A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
        while (!IN_READY && waits < 100) begin
            @(negedge CLK);
            waits++;
        end
        if (!IN_READY) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(a, b, f);
            e.edge_no = cyc + 1 + (((f == 4'h3) && (b != 16'h0)) ? W : 0);
            sb.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {15'h0, OUT_VALID, ALU_OUT, CARRY, DIV_ZERO,
                  Arith_flag, Logic_flag, CMP_flag, Shift_flag, IN_READY}, 32'h0);
    endtask

    always @(negedge CLK) begin
        if (OUT_VALID) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("alu_out",  {16'h0, ALU_OUT},  {16'h0, mon_e.res});
                chk("carry",    {31'h0, CARRY},    {31'h0, mon_e.carry});
                chk("div_zero", {31'h0, DIV_ZERO}, {31'h0, mon_e.dz});
                chk("class",    {28'h0, Arith_flag, Logic_flag, CMP_flag, Shift_flag},
                                {28'h0, mon_e.cls});
                chk("latency",  cyc, mon_e.edge_no);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_state");
        RST = 1'b0;
        #1 chk("ready_after_reset", {31'h0, IN_READY}, 32'd1);
        @(negedge CLK);

        // Back-to-back single-cycle ops
        send(16'hFFFF, 16'h0001, 4'h0, w);
        send(16'h0003, 16'h0005, 4'h1, w);
        send(16'h00FF, 16'h0F0F, 4'h9, w);
        send(16'h0123, 16'h0100, 4'h2, w);
        send(16'hA5A5, 16'h0FF0, 4'h7, w);
        idle(2);

        // Reset for two cycles with a request pending
        RST = 1'b1;
        A = 16'h0001; B = 16'h0002; ALU_FUN = 4'h0; IN_VALID = 1'b1;
        #1 chk("ready_low_in_reset", {31'h0, IN_READY}, 32'd0);
        repeat (2) @(negedge CLK);
        check_reset_outputs("midtraffic_reset_state");
        RST = 1'b0; IN_VALID = 1'b0;
        #1 chk("ready_after_midtraffic_reset", {31'h0, IN_READY}, 32'd1);
        @(negedge CLK);

        // Divide, with the next request held high while the divider runs
        send(16'h1234, 16'h0007, 4'h3, w);
        send(16'h0011, 16'h0022, 4'h0, w);
        chk("div_busy_cycles", w, W);
        idle(2);

        // Divide by zero, then an op that must clear DIV_ZERO
        send(16'h00AA, 16'h0000, 4'h3, w);
        send(16'h00FF, 16'h0F0F, 4'h4, w);
        idle(2);

        // Shifts and compares
        send(16'h8001, 16'h0004, 4'hD, w);
        send(16'h8001, 16'h0004, 4'hF, w);
        send(16'h8001, 16'h000F, 4'hE, w);
        send(16'h0005, 16'h0005, 4'hA, w);
        send(16'h0005, 16'h0005, 4'hB, w);
        send(16'h0004, 16'h0009, 4'hC, w);
        send(16'h4000, 16'h0013, 4'hF, w);
        idle(2);

        // Reset five cycles into a divide: that result must never appear
        send(16'hFFFF, 16'h0003, 4'h3, w);
        IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        sb.delete();
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_mid_divide_state");
        RST = 1'b0;
        idle(W + 4);

        send(16'd100, 16'd10, 4'h3, w);
        idle(W + 3);
        send(16'hFFFF, 16'h0001, 4'h3, w);
        idle(W + 3);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
